// File: rtl/switch_led_pkg.sv
// switch_led_pkg: mode encodings and counter width helper shared by the switch/LED slice
package switch_led_pkg;
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: one switch channel - synchroniser, debounce counter, clean level and rise pulse
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic clean,
  output logic rise
);
  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sy;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sy[SYNC_STAGES-1];
  // any return of s to clean before the terminal count restarts the count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sy    <= '0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sy   <= {sy[SYNC_STAGES-2:0], sw};
      rise <= 1'b0;
      if (s == clean) cnt <= '0;
      else if (cnt == LAST) begin
        clean <= s;
        rise  <= s;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: debounced switches driving LEDs in pass, toggle, blink or invert mode
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise
);
  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);
  logic [BW-1:0] bcnt;
  logic phase;
  logic [WIDTH-1:0] tgl, led_nxt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i])
    );
  end
  always_comb
    led_nxt = (mode == MODE_PASS)   ? sw_clean :
              (mode == MODE_TOGGLE) ? tgl :
              (mode == MODE_BLINK)  ? (sw_clean & {WIDTH{phase}}) : ~sw_clean;
  // toggle state and blink timebase run in every mode so mode changes never lose them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
      tgl   <= '0;
      led   <= '0;
    end else begin
      bcnt  <= (bcnt == BLAST) ? '0 : bcnt + 1'b1;
      phase <= (bcnt == BLAST) ? ~phase : phase;
      tgl   <= tgl ^ sw_rise;
      led   <= led_nxt;
    end
endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb_switch_led_ctrl: directed vectors with hand-computed expectations for switch_led_ctrl
module tb_switch_led_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic [1:0] mode = '0;
  logic [15:0] led, sw_clean, sw_rise;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  switch_led_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .DB_CYCLES(4), .BLINK_HALF(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .mode    (mode),
    .led     (led),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] prev, cur, pv, exp;
    int hits, stray;
    logic early, found;
    sw = 16'hFFFF;
    tick(3);
    chk("rst_led", led, 0);
    chk("rst_clean", sw_clean, 0);
    chk("rst_rise", sw_rise, 0);
    #3 rst_n = 1'b1;
    tick(5);
    chk("rel_clean5", sw_clean, 0);
    tick(1);
    chk("rel_clean6", sw_clean, 16'hFFFF);
    chk("rel_rise6", sw_rise, 16'hFFFF);
    chk("rel_led6", led, 0);
    tick(1);
    chk("rel_led7", led, 16'hFFFF);
    chk("rel_rise7", sw_rise, 0);
    sw = '0;
    tick(20);
    chk("clear_led", led, 0);
    prev = '0;
    for (int i = 0; i < 16; i++) begin
      cur = 16'(1) << i;
      sw = cur;
      hits = 0;
      stray = 0;
      for (int k = 1; k <= 20; k++) begin
        tick(1);
        if (sw_rise == cur) hits++;
        if ((sw_rise & ~cur) != 0) stray++;
        if (k == 6) chk($sformatf("walk%0d_old", i), led, prev);
        if (k == 7) chk($sformatf("walk%0d_new", i), led, cur);
      end
      chk($sformatf("walk%0d_rise", i), hits, 1);
      chk($sformatf("walk%0d_stray", i), stray, 0);
      prev = cur;
    end
    sw = '0;
    tick(20);
    early = 1'b0;
    repeat (5) begin
      sw = 16'h0008;
      repeat (3) begin
        tick(1);
        early |= sw_clean[3] | sw_rise[3];
      end
      sw = '0;
      tick(1);
      early |= sw_clean[3] | sw_rise[3];
    end
    sw = 16'h0008;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      early |= sw_clean[3] | sw_rise[3];
    end
    chk("bounce_early", early, 0);
    tick(1);
    chk("bounce_clean", sw_clean, 16'h0008);
    chk("bounce_rise", sw_rise, 16'h0008);
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      hits += sw_rise[3];
    end
    chk("bounce_extra", hits, 0);
    mode = 2'd1;
    sw = '0;
    tick(20);
    chk("tgl_idle", led, 16'h0008);
    sw = 16'h0001;
    tick(7);
    chk("tgl_lat7", led, 16'h0008);
    tick(1);
    chk("tgl_lat8", led, 16'h0009);
    tick(2);
    sw = '0;
    tick(10);
    chk("tgl_rel1", led, 16'h0009);
    sw = 16'h0001;
    tick(10);
    chk("tgl_press2", led, 16'h0008);
    sw = '0;
    tick(10);
    chk("tgl_rel2", led, 16'h0008);
    mode = 2'd0;
    tick(3);
    chk("tgl_pass", led, 0);
    mode = 2'd1;
    tick(1);
    chk("tgl_kept", led, 16'h0008);
    sw = 16'h00F0;
    mode = 2'd2;
    tick(10);
    pv = led;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (led != pv) begin
        found = 1'b1;
        break;
      end
      pv = led;
    end
    chk("blink_found", found, 1);
    cur = led;
    chk("blink_val", (cur == 16'h00F0) || (cur == 16'h0000), 1);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp = (k >= 8 && k < 16) ? (cur ^ 16'h00F0) : cur;
      chk($sformatf("blink%0d", k), led, exp);
    end
    mode = 2'd3;
    tick(1);
    chk("invert", led, 16'hFF0F);
    mode = 2'd0;
    sw = 16'h0001;
    tick(20);
    mode = 2'd3;
    tick(1);
    chk("ar_pre_led", led, 16'hFFFE);
    sw = 16'h0021;
    tick(4);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_led", led, 0);
    chk("ar_clean", sw_clean, 0);
    chk("ar_rise", sw_rise, 0);
    mode = 2'd0;
    tick(2);
    #3 rst_n = 1'b1;
    tick(5);
    chk("ar_clean5", sw_clean, 0);
    tick(1);
    chk("ar_clean6", sw_clean, 16'h0021);
    tick(1);
    chk("ar_led7", led, 16'h0021);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
